m_unit_ctrl: RTL and testbench
==============================

Name: m_unit_ctrl

Overview:
- Multi-cycle sequencer for the RV32M execute unit.
- Accepts one M-extension operation (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) from the pipeline over a valid/ready handshake.
- Drives the shared m_alu datapath: single-cycle multiply, 32-iteration restoring division, sign/zero-divisor fix-up.
- Returns a registered 32-bit result over a valid/ready handshake; supports pipeline flush.

Parameters:
- DIV_ITERS, 32, number of restoring-division iterations (fixed by XLEN; not for override)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  abort current operation, return to IDLE
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept (state IDLE)
- funct3  in  3  RV32M funct3 (000 MUL … 111 REMU)
- rs1  in  32  dividend / multiplicand
- rs2  in  32  divisor / multiplier
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  32  registered result

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, R/D/Z/counter/flags=0.
- Accept: handshake in IDLE when in_valid & in_ready & !flush. Latch funct3, rs1 and sign flags.
- States:
  - IDLE -> MUL if funct3[2]=0.
  - IDLE -> DIV if funct3[2]=1.
  - MUL -> DONE.
  - DIV -> FIX when counter==0.
  - FIX -> DONE.
  - DONE -> IDLE on out_ready.
- Outputs by state: in_ready=1 only in IDLE; out_valid=1 only in DONE; result held stable while out_valid & !out_ready.
- MUL:
  - A/B are 33-bit operands:
    - MUL, MULH: sign-extend rs1 and rs2.
    - MULHSU: sign-extend rs1, zero-extend rs2.
    - MULHU: zero-extend both.
  - In MUL state, register alu_out[31:0] (MUL) or alu_out[63:32] (others).
  - Latency: out_valid rises 2 cycles after the accept edge.
- DIV setup at accept:
  - Signed ops (DIV/REM): operands converted to magnitude; 0x80000000 magnitude = 0x80000000 unsigned.
  - R=|rs1|, D={|rs2|,31'b0} (63 bit), Z=0, counter=31.
  - neg_q=signed & (rs1[31]^rs2[31]) & (rs2!=0); neg_r=signed & rs1[31]; dbz=(rs2==0).
- DIV iteration (one per cycle, 32 cycles):
  - If !sub_neg: R<=sub_result, Z<={Z[30:0],1}.
  - Else: Z<={Z[30:0],0}.
  - D<=D>>1; counter decrements.
- FIX:
  - mux_div_rem=Z for DIV/DIVU, R for REM/REMU.
  - result = div_rem_neg if the matching neg flag is set, else div_rem.
  - dbz override: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> latched rs1.
  - Division latency is constant 34 cycles (accept edge to out_valid), including dbz.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. Both fall out of the magnitude path with no special case.
- Flush: in any state, next cycle is IDLE with out_valid=0; the result is discarded. Flush in IDLE with in_valid: no accept. Flush with out_valid & out_ready in the same cycle: the transfer is void.
- Reset mid-operation: immediate return to reset values.
- back-to-back: a new op can be accepted in the cycle after DONE->IDLE; there is no accept in the same cycle as result transfer.

Decomposition:
- Shared definitions (m_definitions.svh):
  - state typedef m_state_t {IDLE, MUL, DIV, FIX, DONE};
  - funct3 constants M_MUL … M_REMU;
  - existing MUX_DIV_REM_* constants.
- Sub-module: one instance of m_alu.
  - opcode tied 0.
  - A/B/R/D/Z/mux_div_rem driven by this controller.
  - sub_neg, sub_result, div_rem, div_rem_neg, alu_out consumed by it.

Test Plan:
- MULH rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result 0x00000000 at cycle 2. MULHU same operands -> 0xFFFFFFFE. MUL same operands -> 0x00000001.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD (-3) after 34 cycles. REM same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero: DIV -5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB; DIVU 9/0 -> 0xFFFFFFFF. All after 34 cycles.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure/handshake: hold out_ready=0 for 5 cycles -> out_valid and result stable, in_ready=0. Then out_ready=1 -> IDLE next cycle, and a second op is accepted the following cycle.
- Flush at division cycle 10, and async reset at cycle 20 of a second division -> IDLE/out_valid=0 next cycle, no stale result emitted; a subsequent MUL 6*7 returns 42.

Source files
------------

// File: rtl/m_unit_ctrl_pkg.sv
// Shared types and constants for the RV32M sequencer and its datapath.
// States, funct3 encodings, div/rem result select and a magnitude helper.
package m_unit_ctrl_pkg;

   localparam int DIV_ITERS = 32;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } m_state_t;

   localparam logic [2:0] M_MUL    = 3'b000;
   localparam logic [2:0] M_MULH   = 3'b001;
   localparam logic [2:0] M_MULHSU = 3'b010;
   localparam logic [2:0] M_MULHU  = 3'b011;
   localparam logic [2:0] M_DIV    = 3'b100;
   localparam logic [2:0] M_DIVU   = 3'b101;
   localparam logic [2:0] M_REM    = 3'b110;
   localparam logic [2:0] M_REMU   = 3'b111;

   localparam logic MUX_DIV_REM_Z = 1'b0;
   localparam logic MUX_DIV_REM_R = 1'b1;

   // 0x80000000 maps onto itself, which is its correct unsigned magnitude.
   function automatic logic [31:0] mag(input logic [31:0] x);
      return x[31] ? (32'd0 - x) : x;
   endfunction

endpackage

// File: rtl/m_unit_ctrl_alu.sv
// Shared M-extension datapath: 33x33 multiply, restoring-divide step
// and signed fix-up of the division outcome.
module m_unit_ctrl_alu
   import m_unit_ctrl_pkg::*;
(
   input  logic signed [32:0] a_i,
   input  logic signed [32:0] b_i,
   input  logic [31:0]        r_i,
   input  logic [62:0]        d_i,
   input  logic [31:0]        z_i,
   input  logic               mux_div_rem_i,
   output logic               sub_neg_o,
   output logic [31:0]        sub_result_o,
   output logic [31:0]        div_rem_o,
   output logic [31:0]        div_rem_neg_o,
   output logic [63:0]        alu_out_o
);

   logic signed [63:0] a_x;
   logic signed [63:0] b_x;

   assign a_x = 64'(a_i);
   assign b_x = 64'(b_i);
   assign alu_out_o = a_x * b_x;

   // Upper divisor bits are zero whenever the subtraction is kept.
   assign sub_neg_o    = d_i > {31'd0, r_i};
   assign sub_result_o = r_i - d_i[31:0];

   assign div_rem_o     = (mux_div_rem_i == MUX_DIV_REM_R) ? r_i : z_i;
   assign div_rem_neg_o = 32'd0 - div_rem_o;

endmodule

// File: rtl/m_unit_ctrl.sv
// RV32M execute sequencer: one op in over valid/ready, single-cycle
// multiply or 32-step restoring divide, registered result out.
module m_unit_ctrl
   import m_unit_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   m_state_t    state_q, state_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic [31:0] r_q, r_d;
   logic [62:0] d_q, d_d;
   logic [31:0] z_q, z_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_q_q, neg_q_d;
   logic        neg_r_q, neg_r_d;
   logic        dbz_q, dbz_d;
   logic [31:0] res_q, res_d;

   logic               accept;
   logic               sgn;
   logic signed [32:0] alu_a;
   logic signed [32:0] alu_b;
   logic               mux_div_rem;
   logic               sub_neg;
   logic [31:0]        sub_result;
   logic [31:0]        div_rem;
   logic [31:0]        div_rem_neg;
   logic [63:0]        alu_out;

   assign accept = (state_q == IDLE) && in_valid && !flush;
   assign sgn    = !funct3[0];
   assign result = res_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = funct3[2] ? DIV : MUL;
         MUL:  state_d = DONE;
         DIV:  if (cnt_q == 5'd0) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_comb begin
      in_ready    = (state_q == IDLE);
      out_valid   = (state_q == DONE);
      mux_div_rem = f3_q[1] ? MUX_DIV_REM_R : MUX_DIV_REM_Z;
      alu_a       = {(f3_q != M_MULHU) & op_a_q[31], op_a_q};
      alu_b       = {((f3_q == M_MUL) | (f3_q == M_MULH)) & op_b_q[31],
                     op_b_q};
   end

   always_comb begin
      f3_d    = f3_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      r_d     = r_q;
      d_d     = d_q;
      z_d     = z_q;
      cnt_d   = cnt_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      dbz_d   = dbz_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: if (accept) begin
            f3_d    = funct3;
            op_a_d  = rs1;
            op_b_d  = rs2;
            r_d     = sgn ? mag(rs1) : rs1;
            d_d     = {(sgn ? mag(rs2) : rs2), 31'd0};
            z_d     = '0;
            cnt_d   = 5'(DIV_ITERS - 1);
            neg_q_d = sgn & (rs1[31] ^ rs2[31]) & (rs2 != '0);
            neg_r_d = sgn & rs1[31];
            dbz_d   = (rs2 == '0);
         end
         MUL: res_d = (f3_q == M_MUL) ? alu_out[31:0] : alu_out[63:32];
         DIV: begin
            if (!sub_neg) begin
               r_d = sub_result;
               z_d = {z_q[30:0], 1'b1};
            end else begin
               z_d = {z_q[30:0], 1'b0};
            end
            d_d   = d_q >> 1;
            cnt_d = cnt_q - 5'd1;
         end
         FIX: begin
            if (dbz_q)
               res_d = f3_q[1] ? op_a_q : 32'hFFFF_FFFF;
            else if (f3_q[1] ? neg_r_q : neg_q_q)
               res_d = div_rem_neg;
            else
               res_d = div_rem;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f3_q    <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         r_q     <= '0;
         d_q     <= '0;
         z_q     <= '0;
         cnt_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dbz_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         f3_q    <= f3_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         r_q     <= r_d;
         d_q     <= d_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         dbz_q   <= dbz_d;
         res_q   <= res_d;
      end
   end

   m_unit_ctrl_alu u_m_alu (
      .a_i           (alu_a),
      .b_i           (alu_b),
      .r_i           (r_q),
      .d_i           (d_q),
      .z_i           (z_q),
      .mux_div_rem_i (mux_div_rem),
      .sub_neg_o     (sub_neg),
      .sub_result_o  (sub_result),
      .div_rem_o     (div_rem),
      .div_rem_neg_o (div_rem_neg),
      .alu_out_o     (alu_out)
   );

endmodule

// File: tb/tb_m_unit_ctrl.sv
// Directed bench for m_unit_ctrl: multiply/divide results and latency,
// divide-by-zero, overflow, backpressure, flush and async reset.
module tb_m_unit_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   m_unit_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct3    (funct3),
      .rs1       (rs1),
      .rs2       (rs2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op, wait for the result, check latency and value, drain it.
   task automatic run_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      @(negedge clk);
      funct3 = f3; rs1 = a; rs2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, result, exp);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_drain"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      int stale;
      #1;
      chk("rst_async", {out_valid, in_ready, 30'd0}, 32'h4000_0000);
      chk("rst_result", result, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_ready", {31'd0, in_ready}, 32'd1);

      run_op("mulh_m1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 2);
      run_op("mulhu_m1",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 2);
      run_op("mul_m1",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 2);
      run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, 2);

      run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run_op("divu_100",  3'b101, 32'd100, 32'd7, 32'd14, 34);
      run_op("remu_100",  3'b111, 32'd100, 32'd7, 32'd2, 34);

      run_op("div_dbz",   3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 34);
      run_op("rem_dbz",   3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 34);
      run_op("divu_dbz",  3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 34);

      run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000, 34);
      run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);

      // Backpressure: result held, then back-to-back accept.
      @(negedge clk);
      funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {29'd0, out_valid, in_ready, 1'b0}, 32'd4);
         chk("bp_res", result, 32'd15);
         @(posedge clk); #1;
      end
      @(negedge clk);
      out_ready = 1'b1;
      funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("b2b_idle", {30'd0, out_valid, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_acc", {30'd0, out_valid, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("b2b_done", {30'd0, out_valid, in_ready}, 32'd2);
      chk("b2b_res", result, 32'd6);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Flush while idle with a request pending: nothing is accepted.
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_idle", {31'd0, in_ready}, 32'd1);

      // Flush at division cycle 10.
      @(negedge clk);
      funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_div", {30'd0, out_valid, in_ready}, 32'd1);
      stale = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      chk("flush_stale", 32'(stale), 32'd0);

      // Async reset at cycle 20 of a second division.
      @(negedge clk);
      funct3 = 3'b100; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_mid", {30'd0, out_valid, in_ready}, 32'd1);
      chk("rst_mid_res", result, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      stale = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      chk("rst_stale", 32'(stale), 32'd0);

      run_op("mul_6x7", 3'b000, 32'd6, 32'd7, 32'd42, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
